booth_seq_mult_ctrl: RTL

- Sequential radix-4 Booth multiplier controller for the FIR tap datapath.
- Accepts one signed multiplicand/multiplier pair per transaction over a valid/ready handshake.
- Sequences WIDTH/2 partial-product selections through the (WIDTH+1)-bit 2:1 partial-product muxes, one Booth digit per clock, and accumulates them.
- Presents the signed 2*WIDTH-bit product on a valid/ready output handshake to the FIR accumulator.

---
 rtl/booth_seq_mult_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/booth_seq_mult_ctrl.sv
// booth_seq_mult_ctrl
//   Sequential radix-4 Booth multiplier controller for the FIR tap datapath.
//   One signed operand pair is accepted per transaction, WIDTH/2 Booth digits
//   are retired one per clock, and the signed 2*WIDTH-bit product is offered
//   on a valid/ready handshake.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_ready is high only in IDLE
//   in_a, in_b         signed multiplicand / multiplier
//   abort              synchronous abort, returns to IDLE on the next edge
//   out_valid/out_ready product handshake
//   out_p              signed product, updated only on entry to DONE
//   busy               high in CALC or DONE
//   pp_sel             current Booth triplet {b[2i+1], b[2i], b[2i-1]}, 0 outside CALC
module booth_seq_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic                 busy,
   output logic [2:0]           pp_sel
);

   localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nx;
   logic [WIDTH-1:0]    a_r, b_r;
   logic [2*WIDTH-1:0]  acc, acc_nx;
   logic [CW-1:0]       cnt;

   logic [WIDTH:0]      b_ext, b_sh;
   logic [2:0]          trip;
   // One bit wider than the partial-product mux: -2A of the most negative A
   // (+2^WIDTH) would otherwise wrap and corrupt the product.
   logic [WIDTH+1:0]    a_ext, pp;

   // Triplet extraction with an implicit zero below bit 0.
   assign b_ext = {b_r, 1'b0};
   assign b_sh  = b_ext >> {cnt, 1'b0};
   assign trip  = b_sh[2:0];
   assign a_ext = {{2{a_r[WIDTH-1]}}, a_r};

   always_comb begin
      pp = '0;
      case (trip)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = ~(a_ext << 1) + 1'b1;
         3'b101, 3'b110: pp = ~a_ext + 1'b1;
         default:        pp = '0;
      endcase
   end

   assign acc_nx = acc + ({{(WIDTH-2){pp[WIDTH+1]}}, pp} << {cnt, 1'b0});

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!abort && in_valid) state_nx = CALC;
         CALC:    if (abort) state_nx = IDLE;
                  else if (cnt == LAST) state_nx = DONE;
         DONE:    if (abort || (out_valid && out_ready)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = !in_ready;
   assign pp_sel   = (state == CALC) ? trip : 3'b000;

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         cnt       <= '0;
         out_p     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!abort && in_valid) begin
                  a_r <= in_a;
                  b_r <= in_b;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            CALC: begin
               if (abort) begin
                  acc       <= '0;
                  cnt       <= '0;
                  out_valid <= 1'b0;
               end else begin
                  acc <= acc_nx;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     out_p     <= acc_nx;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (abort) begin
                  acc       <= '0;
                  out_valid <= 1'b0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule
